// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART with TXD/RXD/CON registers, sticky status flags and a level IRQ.
// Latency: tx_out falls the cycle after a TXD write; RXRDY is visible the cycle after the stop-bit sample; irq follows flags by 1 cycle.
// Backpressure: none; a TXD write while TXBUSY=1 is dropped, and a new RX byte overwrites RXD (flagging OVR).
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   rd, wr         bus read / write strobes
//   addr, wdata    bus byte address and write data (wdata[7:0] used)
//   rdata          combinational read data (0 when rd=0 or address unmapped)
//   rx_in, tx_out  serial lines, both idle high
//   irq            registered level interrupt
module uart_periph #(
  parameter int unsigned CLK_PER_BIT = 10417,
  parameter logic [31:0] BASE        = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        irq
);

  localparam logic [31:0] ADDR_TXD  = BASE;
  localparam logic [31:0] ADDR_RXD  = BASE + 32'd4;
  localparam logic [31:0] ADDR_CON  = BASE + 32'd8;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // Bus decode
  logic txd_wr, con_wr, con_rd;
  assign txd_wr = wr && (addr == ADDR_TXD);
  assign con_wr = wr && (addr == ADDR_CON);
  assign con_rd = rd && (addr == ADDR_CON);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // Control / status registers
  logic       txie, rxie, tx_done, rx_rdy, ferr, ovr;
  logic [7:0] rxd;
  logic [7:0] tx_byte;

  // ---------------------------------------------------------------- TX path
  uart_state_t tx_state, tx_state_d;
  logic [15:0] tx_baud, tx_baud_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic        tx_baud_end, tx_done_set, tx_busy, tx_load;

  assign tx_baud_end = (tx_baud == BAUD_LAST);
  assign tx_busy     = (tx_state != ST_IDLE);
  assign tx_load     = txd_wr && !tx_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
    end else begin
      tx_state <= tx_state_d;
      tx_baud  <= tx_baud_d;
      tx_bit   <= tx_bit_d;
      if (tx_load) tx_byte <= wdata[7:0];
    end
  end

  always_comb begin
    tx_state_d  = tx_state;
    tx_baud_d   = tx_baud;
    tx_bit_d    = tx_bit;
    tx_done_set = 1'b0;
    tx_out      = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        tx_baud_d = '0;
        tx_bit_d  = '0;
        if (txd_wr) tx_state_d = ST_START;
      end
      ST_START: begin
        tx_out    = 1'b0;
        tx_baud_d = tx_baud_end ? 16'd0 : tx_baud + 16'd1;
        if (tx_baud_end) tx_state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_out    = tx_byte[tx_bit];
        tx_baud_d = tx_baud_end ? 16'd0 : tx_baud + 16'd1;
        if (tx_baud_end) begin
          tx_bit_d = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_out    = 1'b1;
        tx_baud_d = tx_baud_end ? 16'd0 : tx_baud + 16'd1;
        if (tx_baud_end) begin
          tx_state_d  = ST_IDLE;
          tx_done_set = 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  // Two-flop synchronizer; reset to the idle-high level so reset release
  // never looks like a start bit.
  logic rx_meta, rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  uart_state_t rx_state, rx_state_d;
  logic [15:0] rx_baud, rx_baud_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic        rx_baud_end, rx_ok, rx_ferr_set;

  assign rx_baud_end = (rx_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_baud  <= rx_baud_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state;
    rx_baud_d   = rx_baud;
    rx_bit_d    = rx_bit;
    rx_shift_d  = rx_shift;
    rx_ok       = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        rx_baud_d = '0;
        rx_bit_d  = '0;
        if (!rx_sync) rx_state_d = ST_START;
      end
      ST_START: begin
        // Half-bit wait puts every later sample near mid-bit; a high line here
        // means the falling edge was a glitch.
        if (rx_baud == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_state_d = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          rx_baud_d = rx_baud + 16'd1;
        end
      end
      ST_DATA: begin
        rx_baud_d = rx_baud_end ? 16'd0 : rx_baud + 16'd1;
        if (rx_baud_end) begin
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        rx_baud_d = rx_baud_end ? 16'd0 : rx_baud + 16'd1;
        if (rx_baud_end) begin
          rx_state_d  = ST_IDLE;
          rx_ok       = rx_sync;
          rx_ferr_set = !rx_sync;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------- flags and irq
  // Sticky flags: a set in the same cycle as a CON-read clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      txie    <= 1'b0;
      rxie    <= 1'b0;
      tx_done <= 1'b0;
      rx_rdy  <= 1'b0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
      rxd     <= '0;
      irq     <= 1'b0;
    end else begin
      if (con_wr) begin
        txie <= wdata[0];
        rxie <= wdata[1];
      end
      tx_done <= tx_done_set | (tx_done & ~con_rd);
      rx_rdy  <= rx_ok | (rx_rdy & ~con_rd);
      ovr     <= (rx_ok & rx_rdy) | (ovr & ~con_rd);
      ferr    <= rx_ferr_set | (ferr & ~con_rd);
      if (rx_ok) rxd <= rx_shift;
      irq     <= (txie & tx_done) | (rxie & rx_rdy);
    end
  end

  // ----------------------------------------------------------- read mux
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == ADDR_TXD)      rdata = {24'b0, tx_byte};
      else if (addr == ADDR_RXD) rdata = {24'b0, rxd};
      else if (addr == ADDR_CON) rdata = {25'b0, ovr, ferr, tx_busy, rx_rdy, tx_done, rxie, txie};
    end
  end

endmodule
